// File: rtl/pl_spl_axil_reg_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : pl_spl_axil_reg_slave_if
// Brief    : AXI4-Lite bus bundle for the S00_AXI register slave port.
// Revision : 1.0
// ============================================================================
interface pl_spl_axil_reg_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/pl_spl_axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : pl_spl_axil_reg_slave
// Brief    : AXI4-Lite slave register file with per-register write pulses.
// Revision : 1.0
// ============================================================================
module pl_spl_axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  wire logic                           ACLK,
    input  wire logic                           ARESET,
    pl_spl_axil_reg_slave_if.slave              s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0]      reg_out,
    output logic [NUM_REGS-1:0]                 reg_wr_pulse
);
    localparam int          c_IDX_W       = ADDR_WIDTH - 2;
    localparam int          c_STRB_W      = DATA_WIDTH / 8;
    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    wstate_t                 wstate_q, wstate_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [c_STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     pulse_q, pulse_d;

    rstate_t                 rstate_q, rstate_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;

    logic                    aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0]   eff_addr;
    logic [DATA_WIDTH-1:0]   eff_data;
    logic [c_STRB_W-1:0]     eff_strb;
    logic [c_IDX_W-1:0]      w_idx, r_idx;
    logic                    w_in_range;
    logic                    unused_ok;

    assign aw_hs = s_axi.awvalid & awready_q;
    assign w_hs  = s_axi.wvalid  & wready_q;
    assign ar_hs = s_axi.arvalid & arready_q;

    // A handshake on the commit edge itself must be used directly, not via the holding register.
    assign eff_addr   = aw_hs ? s_axi.awaddr : awaddr_q;
    assign eff_data   = w_hs  ? s_axi.wdata  : wdata_q;
    assign eff_strb   = w_hs  ? s_axi.wstrb  : wstrb_q;
    assign w_idx      = eff_addr[ADDR_WIDTH-1:2];
    assign w_in_range = int'(w_idx) < NUM_REGS;
    assign r_idx      = s_axi.araddr[ADDR_WIDTH-1:2];

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        case (wstate_q)
            W_IDLE: begin
                if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (w_in_range && int'(w_idx) == k) begin
                            pulse_d[k] = 1'b1;
                            for (int b = 0; b < c_STRB_W; b++) begin
                                if (eff_strb[b]) begin
                                    regs_d[k][b*8 +: 8] = eff_data[b*8 +: 8];
                                end
                            end
                        end
                    end
                    bresp_d   = w_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    wstate_d  = W_RESP;
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        awaddr_d  = s_axi.awaddr;
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = s_axi.wdata;
                        wstrb_d  = s_axi.wstrb;
                    end
                    awready_d = ~(aw_held_q | aw_hs);
                    wready_d  = ~(w_held_q | w_hs);
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = c_RESP_OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
        endcase
    end

    // Reads sample regs_q, so a same-edge write commit is not visible to this read.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rstate_d  = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = c_RESP_SLVERR;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (int'(r_idx) == k) begin
                            rdata_d = regs_q[k];
                            rresp_d = c_RESP_OKAY;
                        end
                    end
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            pulse_q   <= '0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            regs_q    <= regs_d;
            pulse_q   <= pulse_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign reg_wr_pulse  = pulse_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end

    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_pl_spl_axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_pl_spl_axil_reg_slave
// Brief    : Randomized self-checking bench against a register-array model.
// Revision : 1.0
// ============================================================================
module tb_pl_spl_axil_reg_slave;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pl_spl_axil_reg_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_axi ();
    logic [NR*DW-1:0] reg_out;
    logic [NR-1:0]    reg_wr_pulse;

    pl_spl_axil_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) u_dut (
        .ACLK         (clk),
        .ARESET       (rst),
        .s_axi        (s_axi),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    logic [31:0] model [NR];
    int n_checks = 0;
    int n_pass   = 0;
    int pulse_seen = 0;
    int pulse_exp  = 0;

    always @(posedge clk) pulse_seen <= pulse_seen + $countones(reg_wr_pulse);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rdata(input logic [AW-1:0] addr);
        int idx = int'(addr) / 4;
        return (idx < NR) ? model[idx] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr);
        return (int'(addr) / 4 < NR) ? 2'b00 : 2'b10;
    endfunction

    task automatic check_regs(input string tag);
        for (int k = 0; k < NR; k++) chk(tag, reg_out[k*DW +: DW], model[k]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        cycle();
        cycle();
        chk("rst_ctrl", 32'({s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.bresp,
                             s_axi.arready, s_axi.rvalid, s_axi.rresp, reg_wr_pulse}), 32'h0);
        chk("rst_rdata", s_axi.rdata, 32'h0);
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
        check_regs("rst_reg");
        rst = 1'b0;
        cycle();
        chk("rst_ready", 32'({s_axi.awready, s_axi.wready, s_axi.arready}), 32'h7);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_hold);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, aw_fire, w_fire, early = 0, rdy_bad = 0;
        int idx = int'(addr) / 4;
        bit inr = idx < NR;
        logic [31:0] nv;
        logic [1:0]  resp_exp;
        s_axi.awaddr = addr; s_axi.wdata = data; s_axi.wstrb = strb;
        while (!(aw_done && w_done) && cyc < 100) begin
            s_axi.awvalid = !aw_done && cyc >= aw_dly;
            s_axi.wvalid  = !w_done  && cyc >= w_dly;
            if (s_axi.bvalid) early = 1;
            if ((aw_done && s_axi.awready) || (w_done && s_axi.wready)) rdy_bad = 1;
            aw_fire = s_axi.awvalid && s_axi.awready;
            w_fire  = s_axi.wvalid  && s_axi.wready;
            cycle();
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        chk("wr_handshake", 32'(aw_done && w_done), 32'h1);
        chk("wr_early_bvalid", 32'(early), 32'h0);
        chk("wr_ready_after_hs", 32'(rdy_bad), 32'h0);
        if (inr) begin
            nv = model[idx];
            for (int b = 0; b < 4; b++) if (strb[b]) nv[b*8 +: 8] = data[b*8 +: 8];
            model[idx] = nv;
            pulse_exp++;
        end
        resp_exp = inr ? 2'b00 : 2'b10;
        chk("bvalid", 32'(s_axi.bvalid), 32'h1);
        chk("bresp", 32'(s_axi.bresp), 32'(resp_exp));
        chk("wr_pulse", 32'(reg_wr_pulse), inr ? 32'(4'b0001 << idx) : 32'h0);
        check_regs("reg_out");
        for (int i = 0; i < b_hold; i++) begin
            s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
            cycle();
            chk("b_hold_valid", 32'(s_axi.bvalid), 32'h1);
            chk("b_hold_resp", 32'(s_axi.bresp), 32'(resp_exp));
            chk("b_hold_ready", 32'({s_axi.awready, s_axi.wready}), 32'h0);
        end
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b1;
        cycle();
        s_axi.bready = 1'b0;
        chk("b_done", 32'(s_axi.bvalid), 32'h0);
        chk("pulse_cleared", 32'(reg_wr_pulse), 32'h0);
        chk("w_ready_back", 32'({s_axi.awready, s_axi.wready}), 32'h3);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp_d,
                            input logic [1:0] exp_r, input int ar_dly, input int r_hold);
        bit fired = 0, fire;
        for (int i = 0; i < ar_dly; i++) cycle();
        s_axi.araddr = addr;
        s_axi.arvalid = 1'b1;
        for (int i = 0; i < 50 && !fired; i++) begin
            fire = s_axi.arready;
            cycle();
            fired = fire;
        end
        s_axi.arvalid = 1'b0;
        chk("rd_handshake", 32'(fired), 32'h1);
        chk("rvalid", 32'(s_axi.rvalid), 32'h1);
        chk("rdata", s_axi.rdata, exp_d);
        chk("rresp", 32'(s_axi.rresp), 32'(exp_r));
        for (int i = 0; i < r_hold; i++) begin
            cycle();
            chk("r_hold", s_axi.rdata, exp_d);
            chk("r_hold_valid", 32'({s_axi.rvalid, s_axi.arready}), 32'h2);
        end
        s_axi.rready = 1'b1;
        cycle();
        s_axi.rready = 1'b0;
        chk("r_done", 32'({s_axi.rvalid, s_axi.arready}), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        logic [31:0]   old;
        s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        do_reset();

        for (int i = 0; i < NR; i++) axi_write(AW'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
        for (int i = 0; i < NR; i++) axi_read(AW'(i*4), 32'(i+1), 2'b00, 0, 0);

        axi_write(5'h00, 32'h11223344, 4'hF, 0, 0, 0);
        axi_write(5'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        axi_read(5'h00, 32'h11BB33DD, 2'b00, 0, 1);

        axi_write(5'h08, 32'h0000CAFE, 4'hF, 3, 0, 0);
        axi_write(5'h07, 32'h12345678, 4'hF, 0, 2, 0);
        axi_write(5'h04, 32'h00000055, 4'hF, 0, 0, 10);
        axi_write(5'h0C, 32'h00000066, 4'hF, 0, 0, 0);
        axi_write(5'h0D, 32'hFFFFFFFF, 4'h0, 0, 0, 0);

        axi_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 1, 0);
        axi_read(5'h10, 32'h0, 2'b10, 0, 0);
        axi_read(5'h1F, 32'h0, 2'b10, 1, 2);

        old = model[1];
        fork
            axi_write(5'h04, 32'h0BADF00D, 4'hF, 0, 0, 0);
            axi_read(5'h04, old, 2'b00, 0, 0);
        join
        axi_read(5'h04, 32'h0BADF00D, 2'b00, 0, 0);

        for (int n = 0; n < 60; n++) begin
            axi_write(AW'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) begin
                a = AW'($urandom_range(0, 31));
                axi_read(a, exp_rdata(a), exp_resp(a),
                         int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            end
        end

        s_axi.awaddr = 5'h04;
        s_axi.awvalid = 1'b1;
        cycle();
        s_axi.awvalid = 1'b0;
        cycle();
        do_reset();
        chk("no_commit_pulse", 32'(reg_wr_pulse), 32'h0);
        axi_write(5'h04, 32'h00001234, 4'hF, 1, 0, 0);
        axi_read(5'h04, 32'h00001234, 2'b00, 0, 0);
        axi_read(5'h00, 32'h0, 2'b00, 0, 0);

        cycle();
        chk("pulse_total", 32'(pulse_seen), 32'(pulse_exp));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
